// File: rtl/ovl_onehot_multi_checker.sv
// ---------------------------------------------------------------------------
// ovl_onehot_multi_checker
//
// Multi-channel one-hot-family assertion checker. Each of CHANNELS vectors of
// WIDTH bits is checked on every enabled rising edge against the encoding rule
// chosen by MODE:
//   0 = zero-one-hot  (at most one bit set)
//   1 = one-hot       (exactly one bit set)
//   2 = one-cold      (exactly one bit clear)
//   3 = zero-one-cold (at most one bit clear)
// A violation must persist for TOLERANCE+1 consecutive enabled samples before
// it is confirmed as an episode. Each confirmed episode pulses fire for one
// cycle, sets fire_sticky and bumps a saturating per-channel counter. The
// earliest confirmed failure (lowest channel wins on a tie) is captured.
//
// Ports
//   i_clock        sampling clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_enable       1 = sample i_test_expr this cycle, 0 = ignore and re-arm
//   i_clear        synchronous clear of run state, counters, flags, capture
//   i_test_expr    channel c at [c*WIDTH +: WIDTH]
//   o_fire         one-cycle pulse per channel on episode confirmation
//   o_fire_sticky  per-channel flag set with o_fire, held until clear/reset
//   o_viol_count   per-channel episode count at [c*CNT_WIDTH +: CNT_WIDTH]
//   o_first_valid  a first failure has been captured
//   o_first_chan   index of the first failing channel
//   o_first_value  sampled vector that confirmed the first failure
// ---------------------------------------------------------------------------
module ovl_onehot_multi_checker #(
  parameter int WIDTH     = 4,
  parameter int CHANNELS  = 2,
  parameter int MODE      = 0,
  parameter int TOLERANCE = 0,
  parameter int CNT_WIDTH = 8,
  parameter int X_CHECK   = 1
) (
  input  logic                                             i_clock,
  input  logic                                             i_reset,
  input  logic                                             i_enable,
  input  logic                                             i_clear,
  input  logic [CHANNELS*WIDTH-1:0]                        i_test_expr,
  output logic [CHANNELS-1:0]                              o_fire,
  output logic [CHANNELS-1:0]                              o_fire_sticky,
  output logic [CHANNELS*CNT_WIDTH-1:0]                    o_viol_count,
  output logic                                             o_first_valid,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] o_first_chan,
  output logic [WIDTH-1:0]                                 o_first_value
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RUN_W = $clog2(TOLERANCE + 2);
  localparam int PC_W  = $clog2(WIDTH + 1);

  // Run counter value one step before confirmation, and its saturation point.
  localparam logic [RUN_W-1:0]     RUN_ARM = RUN_W'(TOLERANCE);
  localparam logic [RUN_W-1:0]     RUN_SAT = RUN_W'(TOLERANCE + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0] w_confirm;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0]     w_vec;
      logic [PC_W-1:0]      w_ones;
      logic [PC_W-1:0]      w_zeros;
      logic                 w_unknown;
      logic                 w_rule_bad;
      logic                 w_viol;
      logic [RUN_W-1:0]     w_run_next;
      logic [RUN_W-1:0]     r_run;
      logic                 r_fire;
      logic                 r_sticky;
      logic [CNT_WIDTH-1:0] r_cnt;

      assign w_vec = i_test_expr[gi*WIDTH +: WIDTH];

      always_comb begin
        w_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
          w_ones = w_ones + PC_W'(w_vec[i]);
        end
      end

      assign w_zeros   = PC_W'(WIDTH) - w_ones;
      assign w_unknown = $isunknown(w_vec);

      always_comb begin
        case (MODE)
          1:       w_rule_bad = (w_ones != PC_W'(1));
          2:       w_rule_bad = (w_zeros != PC_W'(1));
          3:       w_rule_bad = (w_zeros > PC_W'(1));
          default: w_rule_bad = (w_ones > PC_W'(1));
        endcase
      end

      // An unknown sample bypasses the encoding rule entirely; the popcount
      // is meaningless when any bit is X/Z.
      assign w_viol = w_unknown ? (X_CHECK != 0) : w_rule_bad;

      // Confirmation is the transition into TOLERANCE+1. Once saturated the
      // counter sits there, so a persisting violation cannot re-fire.
      assign w_confirm[gi] = i_enable & w_viol & (r_run == RUN_ARM);

      always_comb begin
        w_run_next = '0;
        if (i_enable && w_viol) begin
          if (r_run == RUN_SAT) begin
            w_run_next = r_run;
          end else begin
            w_run_next = r_run + RUN_W'(1);
          end
        end
      end

      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          r_run    <= '0;
          r_fire   <= 1'b0;
          r_sticky <= 1'b0;
          r_cnt    <= '0;
        end else if (i_clear) begin
          // The sample taken with clear is discarded, so the run restarts.
          r_run    <= '0;
          r_fire   <= 1'b0;
          r_sticky <= 1'b0;
          r_cnt    <= '0;
        end else begin
          r_run  <= w_run_next;
          r_fire <= w_confirm[gi];
          if (w_confirm[gi]) begin
            r_sticky <= 1'b1;
            if (r_cnt != CNT_MAX) begin
              r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
          end
        end
      end

      assign o_fire[gi]                              = r_fire;
      assign o_fire_sticky[gi]                       = r_sticky;
      assign o_viol_count[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
    end
  endgenerate

  // Lowest-index confirming channel: scan downward so the last hit wins.
  logic             w_first_hit;
  logic [CH_W-1:0]  w_first_idx;
  logic [WIDTH-1:0] w_first_vec;

  always_comb begin
    w_first_hit = 1'b0;
    w_first_idx = '0;
    w_first_vec = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (w_confirm[c]) begin
        w_first_hit = 1'b1;
        w_first_idx = CH_W'(c);
        w_first_vec = i_test_expr[c*WIDTH +: WIDTH];
      end
    end
  end

  logic             r_first_valid;
  logic [CH_W-1:0]  r_first_chan;
  logic [WIDTH-1:0] r_first_value;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_first_valid <= 1'b0;
      r_first_chan  <= '0;
      r_first_value <= '0;
    end else if (i_clear) begin
      r_first_valid <= 1'b0;
      r_first_chan  <= '0;
      r_first_value <= '0;
    end else if (!r_first_valid && w_first_hit) begin
      r_first_valid <= 1'b1;
      r_first_chan  <= w_first_idx;
      r_first_value <= w_first_vec;
    end
  end

  assign o_first_valid = r_first_valid;
  assign o_first_chan  = r_first_chan;
  assign o_first_value = r_first_value;

endmodule

// File: doc/ovl_onehot_multi_checker.md
# ovl_onehot_multi_checker

Parametrised multi-channel one-hot-family assertion checker for the OVL test suite. It generalises the single-vector zero-one-hot check to CHANNELS independent vectors, with a selectable encoding mode, a persistence tolerance, and per-channel saturating violation counters. A first-failure capture register lets benches and waveform dumps identify the earliest offending channel and value. It sits alongside the other OVL checkers and is driven by the common OVL clock generator.

## Interface
- WIDTH, 4: bits per channel vector (≥2)
- CHANNELS, 2: number of independently checked vectors (≥1)
- MODE, 0: 0 = zero-one-hot (≤1 bit set), 1 = one-hot (exactly 1 set), 2 = one-cold (exactly 1 clear), 3 = zero-one-cold (≤1 clear)
- TOLERANCE, 0: consecutive violating samples allowed before firing; fire on sample TOLERANCE+1
- CNT_WIDTH, 8: width of each per-channel violation-episode counter
- X_CHECK, 1: 1 = any X/Z bit in a sampled channel is a violation; 0 = such a sample counts as passing
- clock  in  1  sampling clock, rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = sample test_expr this cycle; 0 = sample ignored
- clear  in  1  synchronous clear of counters, sticky flags and capture
- test_expr  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- fire  out  CHANNELS  one-cycle pulse per channel when a violation episode is confirmed
- fire_sticky  out  CHANNELS  set with fire, held until clear or reset
- viol_count  out  CHANNELS*CNT_WIDTH  per-channel confirmed-episode count, channel c at [c*CNT_WIDTH +: CNT_WIDTH]
- first_valid  out  1  a first failure has been captured
- first_chan  out  $clog2(CHANNELS) (min 1)  index of first failing channel
- first_value  out  WIDTH  sampled vector that confirmed the first failure

## Operation
- Per channel, a sample is violating if it breaks the MODE rule (or X/Z when X_CHECK=1). Mode 1 treats all-zero as violating; mode 0 does not.
- Per channel run counter (width $clog2(TOLERANCE+2)): enabled violating sample -> increment, saturating at TOLERANCE+1; enabled passing sample -> 0; enable=0 -> 0 (episode broken).
- Episode confirmed when the run counter transitions to TOLERANCE+1. This causes one fire pulse, sets fire_sticky, and increments viol_count, which saturates at 2^CNT_WIDTH-1 and never wraps.
- A persisting violation does not re-fire. The channel re-arms only after a passing sample, an enable=0 cycle, or clear.
- First capture: loads only when first_valid=0 and at least one channel confirms. first_chan is the lowest-index confirming channel in that cycle; first_value is its sample. Later fires leave the capture unchanged.
- Channels are fully independent; simultaneous confirmations on several channels each pulse fire and count in the same cycle.
- clear=1 at a rising edge: all run counters, viol_count, fire_sticky and first_* go to 0 and fire=0. clear overrides a same-cycle confirmation, and that sample is discarded.

## Timing
- Reset (async assert, outputs immediately): fire=0, fire_sticky=0, viol_count=0, first_valid=0, first_chan=0, first_value=0, run counters=0.
- Reset deassertion takes effect at the next rising edge; the first sample is taken on the first edge with reset low.
- Latency: a violating sample at edge N with TOLERANCE=0 gives fire high for cycle N→N+1. Registered outputs update at edge N, together with the count and capture. With TOLERANCE=T, fire follows the (T+1)th consecutive violating edge.
- Reset asserted mid-episode abandons the episode; no fire is produced for pre-reset samples.
- All outputs are registered; no combinational path exists from test_expr to fire.

## Test plan
- W=4, C=1, MODE=0, T=0: reset, then data 0000, 0100, 0001, 1000, 0010, 0000 (several clocks each) -> fire never asserts, viol_count=0, first_valid=0.
- Same config: data 0110 for 3 clocks, then 0001, then 0110 -> fire pulses exactly twice (first 0110 edge, and the edge after re-arm), viol_count=2, first_value=0110, first_chan=0.
- MODE=1, T=2: data 0000 for 2 clocks then 0001 -> no fire. Then 0000 for 3 clocks -> single fire on the third edge, viol_count=1.
- C=2, MODE=0: channel1=1100 and channel0=0011 at the same edge -> fire=11, both counts 1, first_chan=0, first_value=0011. Then clear at the same edge as new violations -> all status 0, no fire.
- CNT_WIDTH=2: alternate 0110/0000 for 5 episodes -> viol_count saturates at 3. Toggling enable=0 during a violation forces a re-fire on the next violating enabled edge.
- X_CHECK=1, data 01X0 -> fire next cycle. With X_CHECK=0 -> no fire. Reset asserted mid-run (T=2, after 2 violating edges) -> outputs clear at once, and there is no fire after release until 3 new violating edges.
